// File: rtl/coax_tx_seq_pkg.sv
// Shared types and helpers for the coax transmit sequencer.
// Holds the sequencer state encoding, requester count and word width.
package coax_tx_seq_pkg;

  localparam int NUM_REQ = 2;
  localparam int WORD_W  = 10;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    START       = 3'd2,
    WAIT_ACTIVE = 3'd3,
    WAIT_DONE   = 3'd4,
    GAP         = 3'd5
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Mux the granted requester's word out of the packed request bus.
  function automatic logic [WORD_W-1:0] sel_word(
    input logic [NUM_REQ*WORD_W-1:0] words,
    input logic [NUM_REQ-1:0]        onehot
  );
    logic [WORD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      acc = acc | (onehot[i] ? words[i*WORD_W +: WORD_W] : {WORD_W{1'b0}});
    end
    return acc;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [NUM_REQ-1:0] onehot);
    logic [PTR_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      p = onehot[i] ? PTR_W'((i + 1) % NUM_REQ) : p;
    end
    return p;
  endfunction

endpackage

// File: rtl/coax_tx_sequencer_if.sv
// Requester and transmitter-facing signal bundle of the coax transmit sequencer.
// master = requesters plus transmitter status; slave = the sequencer itself.
interface coax_tx_sequencer_if;
  import coax_tx_seq_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WORD_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic [WORD_W-1:0]         tx_data;
  logic                      tx_load_strobe;
  logic                      tx_start_strobe;
  logic                      tx_full;
  logic                      tx_active;
  logic                      busy;
  logic                      frame_done;
  logic                      frame_error;

  modport master (
    output req_valid, req_data, req_last, tx_full, tx_active,
    input  req_ready, grant, tx_data, tx_load_strobe, tx_start_strobe,
           busy, frame_done, frame_error
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_full, tx_active,
    output req_ready, grant, tx_data, tx_load_strobe, tx_start_strobe,
           busy, frame_done, frame_error
  );

endinterface

// File: rtl/coax_tx_rr_arbiter.sv
// Picks one requester from a request vector, searching upward from a start pointer.
// COAX_TX_SEQ_FIXED_PRIORITY_EN pins the search start to requester 0.
module coax_tx_rr_arbiter
  import coax_tx_seq_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic [PTR_W-1:0] w_base;

`ifdef COAX_TX_SEQ_FIXED_PRIORITY_EN
  logic [PTR_W-1:0] w_unused_ptr;
  assign w_base       = {PTR_W{1'b0}};
  assign w_unused_ptr = i_ptr;
`else
  assign w_base = i_ptr;
`endif

  // Farthest offset first so the requester nearest the base is assigned last and wins.
  always_comb begin
    int idx;
    o_grant = {NUM_REQ{1'b0}};
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx     = (int'(w_base) + k) % NUM_REQ;
      o_grant = i_req[idx] ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx) : o_grant;
    end
  end

endmodule

// File: rtl/coax_tx_sequencer.sv
// Frame sequencer sharing one coax_buffered_tx between the host and poll requesters.
// Optional build macro: COAX_TX_SEQ_FIXED_PRIORITY_EN (requester 0 always wins ties).
module coax_tx_sequencer
  import coax_tx_seq_pkg::*;
#(
  parameter int GAP_CLOCKS     = 16,
  parameter int ACTIVE_TIMEOUT = 64
) (
  input logic                clk,
  input logic                reset_n,
  coax_tx_sequencer_if.slave bus
);

  localparam int CNT_MAX = max_int(GAP_CLOCKS, ACTIVE_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLOCKS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACTIVE_TIMEOUT - 1);

  seq_state_t         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [WORD_W-1:0]  r_tx_data;
  logic               r_load;
  logic               r_start;
  logic               r_done;
  logic               r_err;

  logic [NUM_REQ-1:0] w_winner;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_hs;
  logic               w_last;
  logic [WORD_W-1:0]  w_word;
  logic [CNT_W-1:0]   w_cnt_inc;

  coax_tx_rr_arbiter u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_winner)
  );

  assign w_ready   = ((r_state == LOAD) && !bus.tx_full) ? r_grant : {NUM_REQ{1'b0}};
  assign w_hs      = |(w_ready & bus.req_valid);
  assign w_last    = |(r_grant & bus.req_last);
  assign w_word    = sel_word(bus.req_data, r_grant);
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : (r_cnt + CNT_ONE);

  // Frame sequencing: grant, word forwarding, start, line-activity tracking and gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_grant   <= {NUM_REQ{1'b0}};
      r_ptr     <= {PTR_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_tx_data <= {WORD_W{1'b0}};
      r_load    <= 1'b0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_load  <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|bus.req_valid) begin
            r_grant <= w_winner;
            r_ptr   <= next_ptr(w_winner);
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_hs) begin
            r_tx_data <= w_word;
            r_load    <= 1'b1;
            if (w_last) begin
              r_state <= START;
            end
          end
        end
        START: begin
          // The FIFO may already have auto-started; the start pulse is still issued.
          r_start <= 1'b1;
          r_cnt   <= {CNT_W{1'b0}};
          r_state <= bus.tx_active ? WAIT_DONE : WAIT_ACTIVE;
        end
        WAIT_ACTIVE: begin
          if (bus.tx_active) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == TMO_LAST) begin
            r_err   <= 1'b1;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= GAP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_active) begin
            r_done  <= 1'b1;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= GAP;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_grant <= {NUM_REQ{1'b0}};
            r_state <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_grant <= {NUM_REQ{1'b0}};
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready       = w_ready;
  assign bus.grant           = r_grant;
  assign bus.tx_data         = r_tx_data;
  assign bus.tx_load_strobe  = r_load;
  assign bus.tx_start_strobe = r_start;
  assign bus.busy            = (r_state != IDLE);
  assign bus.frame_done      = r_done;
  assign bus.frame_error     = r_err;

endmodule

// File: tb/tb_coax_tx_sequencer.sv
// Directed bench for coax_tx_sequencer with a small buffered-transmitter model
// (depth 8, auto-start at 4 words, 80 clocks per word) and load/grant scoreboards.
`timescale 1ns/1ps
module tb_coax_tx_sequencer;
  import coax_tx_seq_pkg::*;

  localparam int GAP         = 16;
  localparam int TMO         = 64;
  localparam int DEPTH       = 8;
  localparam int START_DEPTH = 4;
  localparam int WORD_CLKS   = 80;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  coax_tx_sequencer_if bus();

  coax_tx_sequencer #(.GAP_CLOCKS(GAP), .ACTIVE_TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // transmitter model
  logic m_en = 1'b1;
  logic m_flush = 1'b0;
  logic force_full = 1'b0;
  int   m_cnt, m_timer, m_nc;
  logic m_active, m_pop;

  always_comb begin
    m_pop = m_active && (m_timer == WORD_CLKS - 1);
    m_nc  = m_cnt + (bus.tx_load_strobe ? 1 : 0) - (m_pop ? 1 : 0);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 0; m_timer <= 0; m_active <= 1'b0;
    end else if (m_flush) begin
      m_cnt <= 0; m_timer <= 0; m_active <= 1'b0;
    end else begin
      m_cnt <= m_nc;
      if (m_active) begin
        m_timer <= m_pop ? 0 : m_timer + 1;
        if (m_pop && m_nc == 0) m_active <= 1'b0;
      end else if (m_en && m_nc > 0 && (bus.tx_start_strobe || m_nc >= START_DEPTH)) begin
        m_active <= 1'b1;
        m_timer  <= 0;
      end
    end
  end

  assign bus.tx_active = m_active;
  assign bus.tx_full   = force_full || (m_cnt >= DEPTH);

  // checking
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor and scoreboards
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WORD_W-1:0]  exp_q[$];
  logic [NUM_REQ-1:0] grant_q[$];
  logic [NUM_REQ-1:0] prev_grant = '0;
  int n_load = 0, n_start = 0, n_done = 0, n_err = 0;
  int start_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic start_act = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_load_strobe) begin
      n_load++;
      check("load_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("load_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
    end
    if (bus.grant != '0 && prev_grant == '0) begin
      check("grant_expected", 32'(grant_q.size() != 0), 32'd1);
      if (grant_q.size() != 0) check("grant", 32'(bus.grant), 32'(grant_q.pop_front()));
    end
    prev_grant = bus.grant;
    if (bus.tx_start_strobe) begin n_start++; start_cyc = cyc; start_act = bus.tx_active; end
    if (bus.frame_done)      begin n_done++;  done_cyc  = cyc; end
    if (bus.frame_error)     begin n_err++;   err_cyc   = cyc; end
  end

  // stimulus helpers
  task automatic drive_word(input int r, input logic [WORD_W-1:0] d, input logic last);
    bus.req_valid[r]                  = 1'b1;
    bus.req_data[r*WORD_W +: WORD_W]  = d;
    bus.req_last[r]                   = last;
  endtask

  task automatic wait_hs(input int r, input logic [WORD_W-1:0] d);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready[r] && bus.req_valid[r]) break;
      t++;
      if (t > 3000) begin
        check("handshake_timeout", 32'(t), 32'd0);
        bus.req_valid[r] = 1'b0;
        return;
      end
    end
    exp_q.push_back(d);
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b0;
    bus.req_last[r]  = 1'b0;
  endtask

  task automatic send_frame(input int r, input logic [WORD_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      drive_word(r, base + WORD_W'(i), (i == n - 1));
      wait_hs(r, base + WORD_W'(i));
    end
  endtask

  // which: 0 = frame_done, 1 = frame_error, 2 = start strobe
  task automatic wait_pulse(input string tag, input int which, input int base, input int limit);
    int v;
    for (int t = 0; t < limit; t++) begin
      @(posedge clk);
      case (which)
        1:       v = n_err;
        2:       v = n_start;
        default: v = n_done;
      endcase
      if (v > base) return;
    end
    check({tag, "_timeout"}, 32'(v - base), 32'd1);
  endtask

  task automatic wait_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    check({tag, "_idle_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_grant"},     32'(bus.grant),           32'd0);
    check({tag, "_busy"},      32'(bus.busy),            32'd0);
    check({tag, "_load"},      32'(bus.tx_load_strobe),  32'd0);
    check({tag, "_start"},     32'(bus.tx_start_strobe), 32'd0);
    check({tag, "_done"},      32'(bus.frame_done),      32'd0);
    check({tag, "_error"},     32'(bus.frame_error),     32'd0);
    check({tag, "_ready"},     32'(bus.req_ready),       32'd0);
    check({tag, "_tx_data"},   32'(bus.tx_data),         32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  int b_load, b_start, b_done, b_err, viol;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: basic three-word frame from requester 0
    b_load = n_load; b_start = n_start; b_done = n_done;
    grant_q.push_back(2'b01);
    drive_word(0, 10'h175, 1'b0); wait_hs(0, 10'h175);
    drive_word(0, 10'h28E, 1'b0); wait_hs(0, 10'h28E);
    drive_word(0, 10'h175, 1'b1); wait_hs(0, 10'h175);
    wait_pulse("t1_done", 0, b_done, 1500);
    check("t1_loads", 32'(n_load - b_load), 32'd3);
    check("t1_starts", 32'(n_start - b_start), 32'd1);
    check("t1_dones", 32'(n_done - b_done), 32'd1);
    wait_cyc(done_cyc + GAP - 1);
    check("t1_grant_in_gap", 32'(bus.grant), 32'h1);
    check("t1_busy_in_gap", 32'(bus.busy), 32'd1);
    wait_cyc(done_cyc + GAP);
    check("t1_grant_after_gap", 32'(bus.grant), 32'd0);
    check("t1_busy_after_gap", 32'(bus.busy), 32'd0);

    // 2: both requesters contend, two frames each
    do_reset();
`ifdef COAX_TX_SEQ_FIXED_PRIORITY_EN
    grant_q.push_back(2'b01); grant_q.push_back(2'b01);
    grant_q.push_back(2'b10); grant_q.push_back(2'b10);
`else
    grant_q.push_back(2'b01); grant_q.push_back(2'b10);
    grant_q.push_back(2'b01); grant_q.push_back(2'b10);
`endif
    b_done = n_done;
    fork
      begin send_frame(0, 10'h010, 2); send_frame(0, 10'h020, 2); end
      begin send_frame(1, 10'h110, 2); send_frame(1, 10'h120, 2); end
    join
    wait_pulse("t2_done", 0, b_done + 3, 1500);
    wait_idle("t2");
    check("t2_grants_left", 32'(grant_q.size()), 32'd0);
    check("t2_dones", 32'(n_done - b_done), 32'd4);

    // 3: tx_full stall in LOAD
    grant_q.push_back(2'b01);
    b_load = n_load; b_done = n_done;
    drive_word(0, 10'h0A5, 1'b0); wait_hs(0, 10'h0A5);
    force_full = 1'b1;
    drive_word(0, 10'h15A, 1'b1);
    @(negedge clk);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0 || bus.tx_load_strobe) viol++;
    end
    check("t3_stall_violations", 32'(viol), 32'd0);
    check("t3_loads_during_stall", 32'(n_load - b_load), 32'd1);
    @(posedge clk); #1 force_full = 1'b0;
    wait_hs(0, 10'h15A);
    wait_pulse("t3_done", 0, b_done, 1500);
    check("t3_loads", 32'(n_load - b_load), 32'd2);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    wait_idle("t3");

    // 4: line never goes active -> timeout
    m_en = 1'b0;
    grant_q.push_back(2'b10);
    b_done = n_done; b_err = n_err;
    send_frame(1, 10'h2A0, 3);
    wait_pulse("t4_error", 1, b_err, 500);
    check("t4_error_latency", 32'(err_cyc - start_cyc), 32'd64);
    check("t4_errors", 32'(n_err - b_err), 32'd1);
    wait_cyc(err_cyc + GAP - 1);
    check("t4_busy_in_gap", 32'(bus.busy), 32'd1);
    wait_cyc(err_cyc + GAP);
    check("t4_busy_after_gap", 32'(bus.busy), 32'd0);
    check("t4_grant_after_gap", 32'(bus.grant), 32'd0);
    check("t4_no_done", 32'(n_done - b_done), 32'd0);
    @(posedge clk); #1 m_flush = 1'b1;
    @(posedge clk); #1 begin m_flush = 1'b0; m_en = 1'b1; end

    // 5: five-word frame, FIFO auto-starts before the last word
    grant_q.push_back(2'b01);
    b_load = n_load; b_start = n_start; b_done = n_done; b_err = n_err;
    for (int i = 0; i < 4; i++) begin
      drive_word(0, 10'h300 + 10'(i), 1'b0);
      wait_hs(0, 10'h300 + 10'(i));
    end
    repeat (5) @(posedge clk);
    #1 check("t5_active_before_last", 32'(bus.tx_active), 32'd1);
    drive_word(0, 10'h3FF, 1'b1); wait_hs(0, 10'h3FF);
    wait_pulse("t5_done", 0, b_done, 1500);
    wait_idle("t5");
    check("t5_loads", 32'(n_load - b_load), 32'd5);
    check("t5_starts", 32'(n_start - b_start), 32'd1);
    check("t5_active_at_start", 32'(start_act), 32'd1);
    check("t5_dones", 32'(n_done - b_done), 32'd1);
    check("t5_errors", 32'(n_err - b_err), 32'd0);

    // 6: asynchronous reset while waiting for the line to go idle
    grant_q.push_back(2'b01);
    b_start = n_start;
    send_frame(0, 10'h0C3, 1);
    wait_pulse("t6_start", 2, b_start, 100);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("t6_async");
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    grant_q.push_back(2'b10);
    b_done = n_done;
    send_frame(1, 10'h3C3, 1);
    wait_pulse("t6_done", 0, b_done, 1500);
    wait_idle("t6");
    check("t6_grants_left", 32'(grant_q.size()), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "global timeout");
  end

endmodule
